dll_tx_fc_scheduler: RTL



---
 rtl/dll_pkg.sv | 59 +++++
 rtl/dll_fc_rr_arbiter.sv | 31 +++
 rtl/dll_tx_fc_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dll_pkg.sv
// Shared DLL definitions: DLCMSM state codes, FC type enum, DLLP type
// nibbles and the flow-control DLLP builder.
`timescale 1ns/1ps
package dll_pkg;

  localparam logic [1:0] DL_INACTIVE = 2'b00;
  localparam logic [1:0] DL_INIT1    = 2'b01;
  localparam logic [1:0] DL_INIT2    = 2'b10;
  localparam logic [1:0] DL_ACTIVE   = 2'b11;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_type_e;

  localparam logic [3:0] DLLP_INITFC1_P   = 4'h4;
  localparam logic [3:0] DLLP_INITFC1_NP  = 4'h5;
  localparam logic [3:0] DLLP_INITFC1_CPL = 4'h6;
  localparam logic [3:0] DLLP_INITFC2_P   = 4'hC;
  localparam logic [3:0] DLLP_INITFC2_NP  = 4'hD;
  localparam logic [3:0] DLLP_INITFC2_CPL = 4'hE;
  localparam logic [3:0] DLLP_UPDFC_P     = 4'h8;
  localparam logic [3:0] DLLP_UPDFC_NP    = 4'h9;
  localparam logic [3:0] DLLP_UPDFC_CPL   = 4'hA;

  function automatic fc_type_e fc_next(input fc_type_e t);
    case (t)
      FC_P:    return FC_NP;
      FC_NP:   return FC_CPL;
      default: return FC_P;
    endcase
  endfunction

  function automatic logic [2:0] fc_onehot(input fc_type_e t);
    case (t)
      FC_P:    return 3'b001;
      FC_NP:   return 3'b010;
      FC_CPL:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // DLLP type nibble for a given link phase and FC type
  function automatic logic [3:0] fc_nibble(input logic [1:0] dlc, input fc_type_e t);
    case (dlc)
      DL_INIT1: return (t == FC_P) ? DLLP_INITFC1_P : (t == FC_NP) ? DLLP_INITFC1_NP : DLLP_INITFC1_CPL;
      DL_INIT2: return (t == FC_P) ? DLLP_INITFC2_P : (t == FC_NP) ? DLLP_INITFC2_NP : DLLP_INITFC2_CPL;
      DL_ACTIVE: return (t == FC_P) ? DLLP_UPDFC_P : (t == FC_NP) ? DLLP_UPDFC_NP : DLLP_UPDFC_CPL;
      default:  return 4'h0;
    endcase
  endfunction

  function automatic logic [47:0] build_fc_dllp(input logic [3:0] typ, input logic [2:0] vc,
                                                input logic [7:0] hdr, input logic [11:0] data);
    return {typ, 1'b0, vc, 2'b00, hdr[7:2], hdr[1:0], 2'b00, data[11:8], data[7:0], 16'h0000};
  endfunction

endpackage

// File: rtl/dll_fc_rr_arbiter.sv
// 3-way round-robin arbiter: one-hot grant to the first requester at or after ptr.
`timescale 1ns/1ps
module dll_fc_rr_arbiter
  import dll_pkg::*;
(
  input  logic [2:0] req,
  input  fc_type_e   ptr,
  output logic [2:0] grant
);

  logic [2:0] rot;
  logic [2:0] pick;

  // Rotate so ptr is bit 0, fixed-priority pick, rotate back
  always_comb begin
    rot = req;
    case (ptr)
      FC_NP:   rot = {req[0], req[2], req[1]};
      FC_CPL:  rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    grant = pick;
    case (ptr)
      FC_NP:   grant = {pick[1], pick[0], pick[2]};
      FC_CPL:  grant = {pick[0], pick[2], pick[1]};
      default: grant = pick;
    endcase
  end

endmodule

// File: rtl/dll_tx_fc_scheduler.sv
// TX flow-control DLLP scheduler for one VC: InitFC1/InitFC2 loops during
// link init, UpdateFC on credit release or refresh timer in DL_ACTIVE.
`timescale 1ns/1ps
module dll_tx_fc_scheduler
  import dll_pkg::*;
#(
  parameter int unsigned VC_ID        = 0,
  parameter int unsigned UPDATE_TIMER = 1024,
  parameter int unsigned TIMER_W      = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dlc_state_i,
  input  logic [7:0]  p_hdr_credit_i,
  input  logic [11:0] p_data_credit_i,
  input  logic [7:0]  np_hdr_credit_i,
  input  logic [11:0] np_data_credit_i,
  input  logic [7:0]  cpl_hdr_credit_i,
  input  logic [11:0] cpl_data_credit_i,
  input  logic [2:0]  credit_rel_i,
  output logic [47:0] dllp_o,
  output logic        dllp_valid_o,
  input  logic        dllp_ready_i,
  output logic        init1_done_o,
  output logic        init2_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_INIT1  = 2'b01,
    ST_INIT2  = 2'b10,
    ST_ACTIVE = 2'b11
  } st_e;

  st_e               st, st_target;
  fc_type_e          rr, cur_type, gnt_type;
  logic [2:0]        pending, pend_next, acc_mask, req, grant;
  logic [TIMER_W-1:0] timer;
  logic              state_change, accept, issue, timer_exp;
  logic [7:0]        sel_hdr;
  logic [11:0]       sel_data;

  // Map the DLCMSM code onto the scheduler state it requests
  always_comb begin
    case (dlc_state_i)
      DL_INIT1:  st_target = ST_INIT1;
      DL_INIT2:  st_target = ST_INIT2;
      DL_ACTIVE: st_target = ST_ACTIVE;
      default:   st_target = ST_IDLE;
    endcase
  end

  assign state_change = (st_target != st);
  assign accept       = dllp_valid_o & dllp_ready_i;
  assign timer_exp    = (st == ST_ACTIVE) && (timer == TIMER_W'(UPDATE_TIMER - 1));

  // Init states request every type; ACTIVE requests only pending types
  always_comb begin
    case (st)
      ST_INIT1, ST_INIT2: req = 3'b111;
      ST_ACTIVE:          req = pending;
      default:            req = 3'b000;
    endcase
  end

  dll_fc_rr_arbiter u_arb (
    .req   (req),
    .ptr   (rr),
    .grant (grant)
  );

  assign gnt_type = grant[1] ? FC_NP : grant[2] ? FC_CPL : FC_P;
  assign issue    = !dllp_valid_o && (|grant) && !state_change;

  // Credit fields of the granted type
  always_comb begin
    sel_hdr  = p_hdr_credit_i;
    sel_data = p_data_credit_i;
    case (gnt_type)
      FC_NP: begin
        sel_hdr  = np_hdr_credit_i;
        sel_data = np_data_credit_i;
      end
      FC_CPL: begin
        sel_hdr  = cpl_hdr_credit_i;
        sel_data = cpl_data_credit_i;
      end
      default: ;
    endcase
  end

  // Pending update: accept clears, release or timer expiry sets (set wins)
  always_comb begin
    pend_next = pending;
    if (accept) pend_next = pend_next & ~fc_onehot(cur_type);
    pend_next = pend_next | credit_rel_i;
    if (timer_exp) pend_next = '1;
  end

  // State, handshake, pending, timer and done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= ST_IDLE;
      rr           <= FC_P;
      cur_type     <= FC_P;
      pending      <= '0;
      acc_mask     <= '0;
      timer        <= '0;
      dllp_o       <= '0;
      dllp_valid_o <= 1'b0;
      init1_done_o <= 1'b0;
      init2_done_o <= 1'b0;
    end else if (state_change) begin
      // Any DLCMSM transition aborts the outstanding DLLP and restarts sequencing
      st           <= st_target;
      rr           <= FC_P;
      pending      <= '0;
      acc_mask     <= '0;
      timer        <= '0;
      dllp_valid_o <= 1'b0;
      init1_done_o <= 1'b0;
      init2_done_o <= 1'b0;
    end else begin
      if (accept) begin
        dllp_valid_o <= 1'b0;
        acc_mask     <= acc_mask | fc_onehot(cur_type);
        if (cur_type == FC_CPL && acc_mask[0] && acc_mask[1]) begin
          if (st == ST_INIT1) init1_done_o <= 1'b1;
          if (st == ST_INIT2) init2_done_o <= 1'b1;
        end
      end else if (issue) begin
        dllp_o       <= build_fc_dllp(fc_nibble(dlc_state_i, gnt_type), 3'(VC_ID), sel_hdr, sel_data);
        dllp_valid_o <= 1'b1;
        cur_type     <= gnt_type;
        rr           <= fc_next(gnt_type);
      end
      if (st == ST_ACTIVE) begin
        pending <= pend_next;
        timer   <= timer_exp ? '0 : timer + TIMER_W'(1);
      end
    end
  end

endmodule
